xt_memory_bridge: RTL

- Downstream of the chipset's system bus: consumes `address`, `data_bus`, `memory_read_n` and `memory_write_n`.
- Converts each XT memory cycle inside a configured window into a single request/acknowledge transaction on a generic RAM port.
- Returns read data on `data_bus_ext` with an output enable, and stretches the cycle by holding `io_channel_ready` low until the RAM acknowledges.

---
 rtl/xt_memory_bridge_pkg.sv | 24 ++
 rtl/xt_memory_bridge_bus_strobe_edge.sv | 40 ++++
 rtl/xt_memory_bridge.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/xt_memory_bridge_pkg.sv
// Shared types and constants for the XT memory bridge.
// State encoding, default RAM window and the floating-bus read value.
package xt_memory_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    HOLD     = 2'd2
  } state_e;

  localparam logic [19:0] DEF_RAM_BASE = 20'h00000;
  localparam logic [19:0] DEF_RAM_SIZE = 20'hA0000;
  localparam logic [7:0]  FLOAT_BUS    = 8'hFF;

  // The unsigned offset wraps above 2^20 when addr < base, so one compare covers both bounds.
  function automatic logic in_window(input logic [19:0] addr,
                                     input logic [19:0] base,
                                     input logic [19:0] size);
    logic [20:0] offset;
    offset = {1'b0, addr} - {1'b0, base};
    return offset < {1'b0, size};
  endfunction

endpackage

// File: rtl/xt_memory_bridge_bus_strobe_edge.sv
// Samples the XT memory strobes and turns them into start/release pulses.
// Latency: pulses valid one cycle after the strobe is sampled; no backpressure.
module xt_memory_bridge_bus_strobe_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic read_n_i,
  input  logic write_n_i,
  output logic read_start_o,
  output logic write_start_o,
  output logic release_o,
  output logic read_low_o
);

  logic rd_q, rd_prev_q, wr_q, wr_prev_q;
  logic rd_fall, wr_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q      <= 1'b1;
      rd_prev_q <= 1'b1;
      wr_q      <= 1'b1;
      wr_prev_q <= 1'b1;
    end else begin
      rd_q      <= read_n_i;
      rd_prev_q <= rd_q;
      wr_q      <= write_n_i;
      wr_prev_q <= wr_q;
    end
  end

  assign rd_fall = rd_prev_q & ~rd_q;
  assign wr_fall = wr_prev_q & ~wr_q;

  // Both strobes falling in one sample is not a legal bus cycle.
  assign read_start_o  = rd_fall & ~wr_fall;
  assign write_start_o = wr_fall & ~rd_fall;
  assign release_o     = (~rd_prev_q & rd_q) | (~wr_prev_q & wr_q);
  assign read_low_o    = ~rd_q;

endmodule

// File: rtl/xt_memory_bridge.sv
// Maps in-window XT memory cycles onto a request/acknowledge RAM port, stretching via io_channel_ready.
// Latency: request 1 cycle after strobe sample; ready/data 1 cycle after ack. XT_MEMORY_BRIDGE_TIMEOUT_EN adds an ack timeout.
module xt_memory_bridge
  import xt_memory_bridge_pkg::*;
#(
  parameter logic [19:0] RAM_BASE       = DEF_RAM_BASE,
  parameter logic [19:0] RAM_SIZE       = DEF_RAM_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] address,
  input  logic [7:0]  data_bus,
  input  logic        memory_read_n,
  input  logic        memory_write_n,
  output logic [7:0]  data_bus_ext,
  output logic        data_bus_out_enable,
  output logic        io_channel_ready,
  output logic        ram_request,
  output logic        ram_write,
  output logic [19:0] ram_address,
  output logic [7:0]  ram_write_data,
  input  logic        ram_acknowledge,
  input  logic [7:0]  ram_read_data,
  output logic        bus_error
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        oe_q, oe_d;
  logic        rdy_q, rdy_d;
  logic        abort_q, abort_d;
  logic        done;
  logic [7:0]  done_data;

  logic read_start, write_start, strobe_release, read_low;

  xt_memory_bridge_bus_strobe_edge u_strobe (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .read_n_i      (memory_read_n),
    .write_n_i     (memory_write_n),
    .read_start_o  (read_start),
    .write_start_o (write_start),
    .release_o     (strobe_release),
    .read_low_o    (read_low)
  );

`ifdef XT_MEMORY_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign bus_error = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign bus_error      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b1;
      abort_q <= 1'b0;
`ifdef XT_MEMORY_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      rdy_q   <= rdy_d;
      abort_q <= abort_d;
`ifdef XT_MEMORY_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    oe_d      = oe_q;
    rdy_d     = rdy_q;
    abort_d   = abort_q;
    done      = ram_acknowledge;
    done_data = ram_read_data;
`ifdef XT_MEMORY_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if ((read_start || write_start) && in_window(address, RAM_BASE, RAM_SIZE)) begin
          addr_d  = address;
          wr_d    = write_start;
          if (write_start) wdata_d = data_bus;
          req_d   = 1'b1;
          rdy_d   = 1'b0;
          abort_d = 1'b0;
          state_d = WAIT_ACK;
`ifdef XT_MEMORY_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      WAIT_ACK: begin
`ifdef XT_MEMORY_BRIDGE_TIMEOUT_EN
        if (!ram_acknowledge) begin
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            done      = 1'b1;
            done_data = FLOAT_BUS;
            err_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        if (strobe_release) abort_d = 1'b1;
        if (done) begin
          req_d = 1'b0;
          rdy_d = 1'b1;
          // An aborted cycle still completes on the RAM side but never drives the bus.
          if (abort_q || strobe_release) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            if (!wr_q) begin
              rdata_d = done_data;
              oe_d    = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (strobe_release) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end else begin
          oe_d = !wr_q && read_low;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_bus_ext        = rdata_q;
  assign data_bus_out_enable = oe_q;
  assign io_channel_ready    = rdy_q;
  assign ram_request         = req_q;
  assign ram_write           = wr_q;
  assign ram_address         = addr_q;
  assign ram_write_data      = wdata_q;

endmodule
